// File: rtl/coherence_bus_ctrl_if.sv
// Shared word/RAM-state types and the cache- and RAM-side signal bundle of the coherence bus controller.
// The master modport is the controller; the slave modport is the caches plus the RAM model.
package coherence_bus_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface coherence_bus_ctrl_if #(parameter int CPUS = 2);
    import coherence_bus_pkg::*;

    logic [CPUS-1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
    word_t [CPUS-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]  iwait, dwait, ccwait, ccinv;
    word_t [CPUS-1:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    word_t            ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    modport master (
        input  iREN, dREN, dWEN, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, dREN, dWEN, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Multi-core memory-side controller: round-robin arbitration of fetch/data accesses onto one RAM port,
// with a one-cycle snoop before each data read, dirty-line forwarding and invalidate-on-write-miss.
module coherence_bus_ctrl
    import coherence_bus_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    coherence_bus_ctrl_if.master bus
);

    localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMRD, IFETCH} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   g_reg, g_next, r_reg, r_next;
    logic [GW-1:0]   dptr_reg, dptr_next, iptr_reg, iptr_next;
    logic [CPUS-1:0] dreq;
    logic            d_found, i_found, r_found;
    logic [GW-1:0]   d_sel, i_sel, r_sel;
    logic            acc, req_held, done;
    logic            unused_cctrans;

    assign unused_cctrans = ^bus.cctrans;
    assign dreq = bus.dREN | bus.dWEN;
    assign acc  = (bus.ramstate == ACCESS);

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
        return (int'(v) == CPUS - 1) ? '0 : v + 1'b1;
    endfunction

    // Rotating priority searches plus the lowest-index dirty responder among non-requesters.
    always_comb begin
        logic [GW-1:0] di, ii;
        d_found = 1'b0;
        i_found = 1'b0;
        r_found = 1'b0;
        d_sel   = '0;
        i_sel   = '0;
        r_sel   = '0;
        di      = '0;
        ii      = '0;
        for (int k = 0; k < CPUS; k++) begin
            di = GW'((int'(dptr_reg) + k) % CPUS);
            ii = GW'((int'(iptr_reg) + k) % CPUS);
            if (!d_found && dreq[di]) begin
                d_found = 1'b1;
                d_sel   = di;
            end
            if (!i_found && bus.iREN[ii]) begin
                i_found = 1'b1;
                i_sel   = ii;
            end
            if (!r_found && (GW'(k) != g_reg) && bus.ccwrite[GW'(k)]) begin
                r_found = 1'b1;
                r_sel   = GW'(k);
            end
        end
    end

    // A transaction survives only while its requester keeps the originating request asserted.
    always_comb begin
        case (state_reg)
            WB:                req_held = bus.dWEN[g_reg];
            SNOOP, C2C, RAMRD: req_held = bus.dREN[g_reg];
            IFETCH:            req_held = bus.iREN[g_reg];
            default:           req_held = 1'b0;
        endcase
    end

    assign done = acc && req_held && (state_reg != IDLE) && (state_reg != SNOOP);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            g_reg     <= '0;
            r_reg     <= '0;
            dptr_reg  <= '0;
            iptr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
            r_reg     <= r_next;
            dptr_reg  <= dptr_next;
            iptr_reg  <= iptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        r_next     = r_reg;
        dptr_next  = dptr_reg;
        iptr_next  = iptr_reg;
        case (state_reg)
            IDLE: begin
                if (d_found) begin
                    g_next     = d_sel;
                    state_next = bus.dWEN[d_sel] ? WB : SNOOP;
                end else if (i_found) begin
                    g_next     = i_sel;
                    state_next = IFETCH;
                end
            end
            SNOOP: begin
                if (!req_held) begin
                    state_next = IDLE;
                end else if (r_found) begin
                    r_next     = r_sel;
                    state_next = C2C;
                end else begin
                    state_next = RAMRD;
                end
            end
            WB, C2C, RAMRD: begin
                if (!req_held) begin
                    state_next = IDLE;
                end else if (acc) begin
                    dptr_next  = wrap_inc(g_reg);
                    state_next = IDLE;
                end
            end
            IFETCH: begin
                if (!req_held) begin
                    state_next = IDLE;
                end else if (acc) begin
                    iptr_next  = wrap_inc(g_reg);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.iload       = '0;
        bus.dload       = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        case (state_reg)
            WB: begin
                bus.ramWEN        = 1'b1;
                bus.ramaddr       = bus.daddr[g_reg];
                bus.ramstore      = bus.dstore[g_reg];
                bus.dwait[g_reg]  = !done;
            end
            SNOOP, C2C, RAMRD: begin
                // Other caches stay stalled on the snooped line for the whole read.
                for (int j = 0; j < CPUS; j++) begin
                    if (GW'(j) != g_reg) begin
                        bus.ccwait[j]      = 1'b1;
                        bus.ccsnoopaddr[j] = bus.daddr[g_reg];
                        if (state_reg == SNOOP) bus.ccinv[j] = bus.ccwrite[g_reg];
                    end
                end
                if (state_reg == C2C) begin
                    bus.ramWEN       = 1'b1;
                    bus.ramaddr      = bus.daddr[g_reg];
                    bus.ramstore     = bus.dstore[r_reg];
                    bus.dload[g_reg] = bus.dstore[r_reg];
                    bus.dwait[g_reg] = !done;
                end else if (state_reg == RAMRD) begin
                    bus.ramREN       = 1'b1;
                    bus.ramaddr      = bus.daddr[g_reg];
                    bus.dload[g_reg] = bus.ramload;
                    bus.dwait[g_reg] = !done;
                end
            end
            IFETCH: begin
                bus.ramREN       = 1'b1;
                bus.ramaddr      = bus.iaddr[g_reg];
                bus.iload[g_reg] = bus.ramload;
                bus.iwait[g_reg] = !done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed scenarios followed by randomized traffic
// checked against a transaction-level model of arbitration, snooping and RAM responses.
module tb_coherence_bus_ctrl;
    import coherence_bus_pkg::*;

    localparam int CPUS = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   tests = 0;
    int   fails = 0;

    coherence_bus_ctrl_if #(.CPUS(CPUS)) bus ();
    coherence_bus_ctrl #(.CPUS(CPUS)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.ccwrite = '0; bus.cctrans = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        tests++;
        if (bus.iwait !== 2'b11 || bus.dwait !== 2'b11) begin
            fails++; $display("FAIL reset_waits: iwait=%b dwait=%b want 11/11", bus.iwait, bus.dwait);
        end
        tests++;
        if ({bus.ramREN, bus.ramWEN, bus.ccwait, bus.ccinv} !== 6'b0) begin
            fails++; $display("FAIL reset_strobes: ren=%b wen=%b ccwait=%b ccinv=%b want 0", bus.ramREN, bus.ramWEN, bus.ccwait, bus.ccinv);
        end
        @(posedge CLK); #1 nRST = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_ifetch();
        @(posedge CLK); #1;
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100; bus.ramstate = BUSY;
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b0) begin fails++; $display("FAIL ifetch_idle: ramREN=%b want 0", bus.ramREN); end
        @(posedge CLK); #1;
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.iwait !== 2'b11) begin
            fails++; $display("FAIL ifetch_busy: ren=%b addr=%h iwait=%b want 1/100/11", bus.ramREN, bus.ramaddr, bus.iwait);
        end
        @(posedge CLK); #1;
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        @(negedge CLK);
        tests++;
        if (bus.iwait !== 2'b10 || bus.iload[0] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL ifetch_done: iwait=%b iload0=%h want 10/deadbeef", bus.iwait, bus.iload[0]);
        end
        @(posedge CLK); #1;
        bus.iREN = '0; bus.ramstate = FREE;
        @(negedge CLK);
        tests++;
        if (bus.iwait !== 2'b11) begin fails++; $display("FAIL ifetch_pulse: iwait=%b want 11", bus.iwait); end
        $display("[TB] ifetch core0 addr 00000100 done");
    endtask

    task automatic test_c2c();
        @(posedge CLK); #1;
        bus.dREN = 2'b10; bus.daddr[1] = 32'h40; bus.ccwrite = 2'b11;
        bus.dstore[0] = 32'hCAFEF00D; bus.dstore[1] = 32'h11111111; bus.ramstate = BUSY;
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if (bus.ccwait !== 2'b01 || bus.ccinv !== 2'b01 || bus.ccsnoopaddr[0] !== 32'h40) begin
            fails++; $display("FAIL c2c_snoop: ccwait=%b ccinv=%b snoop0=%h want 01/01/40", bus.ccwait, bus.ccinv, bus.ccsnoopaddr[0]);
        end
        tests++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
            fails++; $display("FAIL c2c_snoop_strobe: ren=%b wen=%b want 0/0", bus.ramREN, bus.ramWEN);
        end
        @(posedge CLK); #1 bus.ramstate = ACCESS;
        @(negedge CLK);
        tests++;
        if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.ramstore !== 32'hCAFEF00D) begin
            fails++; $display("FAIL c2c_ram: wen=%b addr=%h store=%h want 1/40/cafef00d", bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        tests++;
        if (bus.dload[1] !== 32'hCAFEF00D || bus.dwait !== 2'b01) begin
            fails++; $display("FAIL c2c_load: dload1=%h dwait=%b want cafef00d/01", bus.dload[1], bus.dwait);
        end
        @(posedge CLK); #1;
        clear_inputs();
        $display("[TB] c2c core1 <- core0 addr 00000040 done");
    endtask

    task automatic test_wb_then_fetch();
        @(posedge CLK); #1;
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h80; bus.dstore[0] = 32'h12345678;
        bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h200; bus.ramstate = ACCESS; bus.ramload = 32'h0BADF00D;
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h80 || bus.ramstore !== 32'h12345678) begin
            fails++; $display("FAIL wb_ram: wen=%b addr=%h store=%h want 1/80/12345678", bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        tests++;
        if (bus.dwait !== 2'b10 || bus.iwait !== 2'b11) begin
            fails++; $display("FAIL wb_waits: dwait=%b iwait=%b want 10/11", bus.dwait, bus.iwait);
        end
        @(posedge CLK); #1 bus.dWEN = '0;
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 2'b11) begin
            fails++; $display("FAIL wb_gap: ren=%b wen=%b iwait=%b want 0/0/11", bus.ramREN, bus.ramWEN, bus.iwait);
        end
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200 || bus.iwait !== 2'b01 || bus.iload[1] !== 32'h0BADF00D) begin
            fails++; $display("FAIL wb_fetch: ren=%b addr=%h iwait=%b iload1=%h want 1/200/01/0badf00d", bus.ramREN, bus.ramaddr, bus.iwait, bus.iload[1]);
        end
        @(posedge CLK); #1;
        clear_inputs();
        $display("[TB] wb core0 then fetch core1 done");
    endtask

    task automatic test_round_robin();
        int order[$];
        @(posedge CLK); #1;
        bus.dREN = 2'b11; bus.ccwrite = '0; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20;
        bus.ramstate = ACCESS;
        for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
            @(negedge CLK);
            if (bus.dwait !== 2'b11) order.push_back(bus.dwait[0] ? 1 : 0);
        end
        @(posedge CLK); #1;
        clear_inputs();
        tests++;
        if (order.size() != 4) begin
            fails++; $display("FAIL rr_timeout: completions=%0d want 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                int exp_core;
                exp_core = (i % 2 == 0) ? 1 : 0;
                tests++;
                if (order[i] != exp_core) begin
                    fails++; $display("FAIL rr_order[%0d]: core=%0d want %0d", i, order[i], exp_core);
                end
                $display("[TB] rr read served core %0d", order[i]);
            end
        end
    endtask

    task automatic test_abort();
        @(posedge CLK); #1;
        bus.dREN = 2'b10; bus.daddr[1] = 32'h60; bus.ramstate = BUSY;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h60) begin
            fails++; $display("FAIL abort_rd: ren=%b addr=%h want 1/60", bus.ramREN, bus.ramaddr);
        end
        @(posedge CLK); #1 bus.dREN = '0;
        @(negedge CLK);
        tests++;
        if (bus.dwait !== 2'b11) begin fails++; $display("FAIL abort_wait: dwait=%b want 11", bus.dwait); end
        @(posedge CLK); #1 bus.dREN = 2'b11;
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
            fails++; $display("FAIL abort_idle: ren=%b wen=%b want 0/0", bus.ramREN, bus.ramWEN);
        end
        @(negedge CLK);
        tests++;
        if (bus.ccwait !== 2'b01) begin fails++; $display("FAIL abort_ptr: ccwait=%b want 01 (core1 regranted)", bus.ccwait); end
        $display("[TB] abort core1 read, pointer kept");
    endtask

    task automatic test_reset_mid_read();
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b1) begin fails++; $display("FAIL rst_pre: ramREN=%b want 1", bus.ramREN); end
        #1 nRST = 1'b0;
        #1;
        tests++;
        if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11 || bus.iwait !== 2'b11) begin
            fails++; $display("FAIL rst_async: ren=%b dwait=%b iwait=%b want 0/11/11", bus.ramREN, bus.dwait, bus.iwait);
        end
        @(posedge CLK); #1 nRST = 1'b1;
        @(negedge CLK);
        tests++;
        if (bus.ramREN !== 1'b0 || bus.ccwait !== 2'b00) begin
            fails++; $display("FAIL rst_idle: ren=%b ccwait=%b want 0/00", bus.ramREN, bus.ccwait);
        end
        @(negedge CLK);
        tests++;
        if (bus.ccwait !== 2'b10) begin fails++; $display("FAIL rst_first_grant: ccwait=%b want 10 (core0)", bus.ccwait); end
        @(posedge CLK); #1;
        clear_inputs();
        $display("[TB] reset mid-read, first grant core0");
    endtask

    // Transaction-level model: one access in flight; a new grant is chosen on each idle cycle.
    task automatic test_random();
        int dptr_m, iptr_m, tc, tresp, txns;
        byte tkind;
        bit busy, snooped, chk_store, chk_load;
        bit [CPUS-1:0] clr_d, clr_i;
        logic [CPUS-1:0] ew_i, ew_d, ecw, eci;
        logic eren, ewen;
        word_t eaddr, estore, eload, aload;
        @(posedge CLK); #1;
        clear_inputs(); nRST = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        dptr_m = 0; iptr_m = 0; tc = 0; tresp = -1; txns = 0; tkind = "W";
        busy = 1'b0; snooped = 1'b0; clr_d = '0; clr_i = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge CLK); #1;
            if (!busy) begin
                for (int c = 0; c < CPUS; c++) begin
                    if (clr_d[c]) begin bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0; end
                    if (clr_i[c]) bus.iREN[c] = 1'b0;
                    if (!(bus.dREN[c] || bus.dWEN[c])) begin
                        bus.dstore[c] = $urandom;
                        if ($urandom_range(0, 2) == 0) begin
                            if ($urandom_range(0, 1) == 1) bus.dWEN[c] = 1'b1; else bus.dREN[c] = 1'b1;
                            bus.daddr[c] = $urandom & 32'hFFFC;
                        end
                    end
                    if (!bus.iREN[c] && $urandom_range(0, 2) == 0) begin
                        bus.iREN[c] = 1'b1; bus.iaddr[c] = $urandom & 32'hFFFC;
                    end
                    bus.ccwrite[c] = 1'($urandom_range(0, 1));
                end
                clr_d = '0; clr_i = '0;
            end
            case ($urandom_range(0, 5))
                0: bus.ramstate = FREE;
                1: bus.ramstate = BUSY;
                2: bus.ramstate = ERROR;
                default: bus.ramstate = ACCESS;
            endcase
            bus.ramload = $urandom;
            @(negedge CLK);
            ew_i = '1; ew_d = '1; ecw = '0; eci = '0; eren = 1'b0; ewen = 1'b0;
            eaddr = '0; estore = '0; eload = '0; chk_store = 1'b0; chk_load = 1'b0;
            if (!busy) begin
                for (int k = 0; k < CPUS; k++) begin
                    int c;
                    c = (dptr_m + k) % CPUS;
                    if (!busy && (bus.dREN[c] || bus.dWEN[c])) begin
                        busy = 1'b1; tc = c; tkind = bus.dWEN[c] ? "W" : "R";
                    end
                end
                for (int k = 0; k < CPUS; k++) begin
                    int c;
                    c = (iptr_m + k) % CPUS;
                    if (!busy && bus.iREN[c]) begin busy = 1'b1; tc = c; tkind = "I"; end
                end
                snooped = 1'b0;
            end else if (tkind == "R" && !snooped) begin
                tresp = -1;
                for (int j = 0; j < CPUS; j++) begin
                    if (j != tc) begin
                        ecw[j] = 1'b1; eci[j] = bus.ccwrite[tc];
                        tests++;
                        if (bus.ccsnoopaddr[j] !== bus.daddr[tc]) begin
                            fails++; $display("FAIL rnd_snoopaddr c%0d cyc %0d: got %h want %h", j, cyc, bus.ccsnoopaddr[j], bus.daddr[tc]);
                        end
                        if (tresp < 0 && bus.ccwrite[j]) tresp = j;
                    end
                end
                snooped = 1'b1;
            end else begin
                if (tkind == "W") begin
                    ewen = 1'b1; eaddr = bus.daddr[tc]; estore = bus.dstore[tc]; chk_store = 1'b1;
                end else if (tkind == "I") begin
                    eren = 1'b1; eaddr = bus.iaddr[tc]; eload = bus.ramload; chk_load = 1'b1;
                end else begin
                    for (int j = 0; j < CPUS; j++) if (j != tc) ecw[j] = 1'b1;
                    eaddr = bus.daddr[tc]; chk_load = 1'b1;
                    if (tresp >= 0) begin
                        ewen = 1'b1; estore = bus.dstore[tresp]; chk_store = 1'b1; eload = bus.dstore[tresp];
                    end else begin
                        eren = 1'b1; eload = bus.ramload;
                    end
                end
                if (bus.ramstate == ACCESS) begin
                    if (tkind == "I") begin
                        ew_i[tc] = 1'b0; iptr_m = (tc + 1) % CPUS; clr_i[tc] = 1'b1;
                    end else begin
                        ew_d[tc] = 1'b0; dptr_m = (tc + 1) % CPUS; clr_d[tc] = 1'b1;
                    end
                    busy = 1'b0; txns++;
                    $display("[TB] rnd txn %0d: core %0d kind %c addr %h resp %0d", txns, tc, tkind, eaddr, (tkind == "R") ? tresp : -1);
                end
            end
            tests++;
            if (bus.iwait !== ew_i || bus.dwait !== ew_d) begin
                fails++; $display("FAIL rnd_waits cyc %0d: iwait=%b dwait=%b want %b/%b", cyc, bus.iwait, bus.dwait, ew_i, ew_d);
            end
            tests++;
            if (bus.ramREN !== eren || bus.ramWEN !== ewen) begin
                fails++; $display("FAIL rnd_strobes cyc %0d: ren=%b wen=%b want %b/%b", cyc, bus.ramREN, bus.ramWEN, eren, ewen);
            end
            tests++;
            if (bus.ccwait !== ecw || bus.ccinv !== eci) begin
                fails++; $display("FAIL rnd_cc cyc %0d: ccwait=%b ccinv=%b want %b/%b", cyc, bus.ccwait, bus.ccinv, ecw, eci);
            end
            if (eren || ewen) begin
                tests++;
                if (bus.ramaddr !== eaddr) begin
                    fails++; $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, bus.ramaddr, eaddr);
                end
            end
            if (chk_store) begin
                tests++;
                if (bus.ramstore !== estore) begin
                    fails++; $display("FAIL rnd_store cyc %0d: got %h want %h", cyc, bus.ramstore, estore);
                end
            end
            if (chk_load) begin
                aload = (tkind == "I") ? bus.iload[tc] : bus.dload[tc];
                tests++;
                if (aload !== eload) begin
                    fails++; $display("FAIL rnd_load cyc %0d: got %h want %h", cyc, aload, eload);
                end
            end
        end
        tests++;
        if (txns < 50) begin fails++; $display("FAIL rnd_progress: transactions=%0d want >= 50", txns); end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_c2c();
        test_wb_then_fetch();
        test_round_robin();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
